// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: queue entry, FSM states and
// the default boot vector.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

    localparam word_t DEFAULT_RESET_PC = 32'hbfc0_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Small {pc, instr} FIFO between fetch and decode. The head entry is kept in
// a register so out_* hold their last value once the queue drains.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0]   cnt_next;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        rd_next  = pop ? rd_ptr + PW'(1) : rd_ptr;
        cnt_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_next;
            count  <= cnt_next;
            // The next head is either already in memory or is the word being
            // written this cycle into the slot that becomes the head.
            if (cnt_next != '0)
                head <= (push && wr_ptr == rd_next) ? push_entry : mem[rd_next];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs a one-outstanding request
// FSM on the instruction bus and queues {pc, instr} pairs for decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC  = DEFAULT_RESET_PC,
    parameter int    BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state;
    word_t           pc, inflight_pc;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop, handshake;
    fetch_entry_t    head, push_entry;

    assign ireq_addr  = pc;
    assign handshake  = ireq_valid && ireq_ready;
    assign push       = (state == WAIT) && iresp_valid && !redirect_valid;
    assign pop        = out_valid && !stall;
    assign push_entry = '{pc: inflight_pc, instr: iresp_data};
    assign out_valid  = !empty;
    assign out_pc     = head.pc;
    assign out_instr  = head.instr;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            ireq_valid  <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            ireq_valid <= 1'b0;
            // Anything the bus has accepted must still be drained in DROP.
            case (state)
                IDLE:    state <= IDLE;
                REQ:     state <= handshake   ? DROP : IDLE;
                WAIT:    state <= iresp_valid ? IDLE : DROP;
                default: state <= iresp_valid ? IDLE : DROP;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    // Free slots ignore a same-cycle pop, so one bubble per fetch.
                    if (count < CW'(BUF_DEPTH)) begin
                        state      <= REQ;
                        ireq_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (ireq_ready) begin
                        inflight_pc <= pc;
                        pc          <= pc + 32'd4;
                        ireq_valid  <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: if (iresp_valid) state <= IDLE;
                default: if (iresp_valid) state <= IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset)
            assert (!(push && full && !pop));
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table for the basic
// fetch stream, then hand-written stall, redirect and reset sequences.
module tb_fetch_stage;

    typedef logic [31:0] word_t;
    localparam word_t B = 32'hbfc0_0000;
    localparam word_t K = 32'h5a5a_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_chk = 0;
    int n_pass = 0;

    logic  bus_ready;
    int    resp_lat;
    logic  pend;
    int    pend_wait;
    word_t pend_addr;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_ready     (ireq_ready),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  rdy;
        logic  rv;
        word_t rd;
        logic  iv;
        word_t ia;
        logic  ov;
        word_t op;
        word_t oi;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic rdy, logic rv, word_t rd, logic iv, word_t ia,
                                logic ov, word_t op, word_t oi);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.iv = iv; v.ia = ia;
        v.ov = ov; v.op = op; v.oi = oi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ireq_ready = 0; iresp_valid = 0; iresp_data = 0;
        stall = 0; redirect_valid = 0; redirect_pc = 0;
        pend = 0; pend_wait = 0; pend_addr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Bus model: accepts when bus_ready, answers resp_lat cycles after the handshake.
    task automatic tick();
        logic  hs;
        word_t a;
        ireq_ready  = bus_ready;
        iresp_valid = pend && (pend_wait == 0);
        iresp_data  = pend_addr ^ K;
        hs = ireq_valid && bus_ready;
        a  = ireq_addr;
        @(posedge clk);
        #1;
        if (iresp_valid) pend = 0;
        else if (pend) pend_wait--;
        if (hs) begin
            pend = 1; pend_addr = a; pend_wait = resp_lat - 1;
        end
        redirect_valid = 0;
        @(negedge clk);
    endtask

    task automatic wait_out(input string name);
        for (int n = 0; n < 40 && !out_valid; n++) tick();
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_req(input string name);
        for (int n = 0; n < 40 && !ireq_valid; n++) tick();
        chk({name, " ireq_valid"}, 32'(ireq_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nreq;
        //               rdy rv data        iv addr   ov pc     instr
        tbl[0]  = mk(1, 0, 0,           0, B,      0, 0,     0);
        tbl[1]  = mk(1, 0, 0,           1, B,      0, 0,     0);
        tbl[2]  = mk(0, 1, 32'h1111_0000, 0, B+4,  0, 0,     0);
        tbl[3]  = mk(1, 0, 0,           0, B+4,    1, B,     32'h1111_0000);
        tbl[4]  = mk(1, 0, 0,           1, B+4,    0, 0,     0);
        tbl[5]  = mk(0, 1, 32'h2222_0001, 0, B+8,  0, 0,     0);
        tbl[6]  = mk(1, 0, 0,           0, B+8,    1, B+4,   32'h2222_0001);
        tbl[7]  = mk(1, 0, 0,           1, B+8,    0, 0,     0);
        tbl[8]  = mk(0, 1, 32'h3333_0002, 0, B+12, 0, 0,     0);
        tbl[9]  = mk(0, 0, 0,           0, B+12,   1, B+8,   32'h3333_0002);
        tbl[10] = mk(0, 0, 0,           1, B+12,   0, 0,     0);
        tbl[11] = mk(0, 0, 0,           1, B+12,   0, 0,     0);
        tbl[12] = mk(1, 0, 0,           1, B+12,   0, 0,     0);
        tbl[13] = mk(0, 1, 32'h4444_0003, 0, B+16, 0, 0,     0);
        tbl[14] = mk(0, 0, 0,           0, B+16,   1, B+12,  32'h4444_0003);

        do_reset();
        chk("rst ireq_valid", 32'(ireq_valid), 32'd0);
        chk("rst ireq_addr", ireq_addr, B);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst out_instr", out_instr, 32'd0);

        for (int i = 0; i < 15; i++) begin
            chk($sformatf("vec%0d ireq_valid", i), 32'(ireq_valid), 32'(tbl[i].iv));
            chk($sformatf("vec%0d ireq_addr", i), ireq_addr, tbl[i].ia);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d out_pc", i), out_pc, tbl[i].op);
                chk($sformatf("vec%0d out_instr", i), out_instr, tbl[i].oi);
            end
            ireq_ready  = tbl[i].rdy;
            iresp_valid = tbl[i].rv;
            iresp_data  = tbl[i].rd;
            @(posedge clk);
            @(negedge clk);
        end

        // Stall fills the queue, fetch stops, then drains in order.
        do_reset();
        bus_ready = 1; resp_lat = 1; stall = 1; nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (ireq_valid) nreq++;
            tick();
        end
        chk("stall req count", nreq, 32'd2);
        chk("stall ireq_valid", 32'(ireq_valid), 32'd0);
        chk("stall out_pc", out_pc, B);
        chk("stall out_instr", out_instr, B ^ K);
        stall = 0;
        tick();
        chk("drain1 out_valid", 32'(out_valid), 32'd1);
        chk("drain1 out_pc", out_pc, B + 4);
        chk("drain1 out_instr", out_instr, (B + 4) ^ K);
        tick();
        chk("drain2 out_valid", 32'(out_valid), 32'd0);
        chk("resume ireq_valid", 32'(ireq_valid), 32'd1);
        chk("resume ireq_addr", ireq_addr, B + 8);
        wait_out("resume");
        chk("resume out_pc", out_pc, B + 8);

        // Redirect while waiting on a slow response.
        do_reset();
        bus_ready = 1; resp_lat = 3;
        tick();
        tick();
        redirect_valid = 1; redirect_pc = 32'h8000_0010;
        tick();
        chk("redirW ireq_valid", 32'(ireq_valid), 32'd0);
        chk("redirW out_valid", 32'(out_valid), 32'd0);
        wait_req("redirW");
        chk("redirW ireq_addr", ireq_addr, 32'h8000_0010);
        wait_out("redirW");
        chk("redirW out_pc", out_pc, 32'h8000_0010);
        chk("redirW out_instr", out_instr, 32'h8000_0010 ^ K);

        // Redirect coinciding with the request handshake; target is unaligned.
        do_reset();
        bus_ready = 1; resp_lat = 1;
        tick();
        chk("redirH pre ireq_valid", 32'(ireq_valid), 32'd1);
        redirect_valid = 1; redirect_pc = 32'h0000_1003;
        tick();
        chk("redirH ireq_valid", 32'(ireq_valid), 32'd0);
        chk("redirH ireq_addr", ireq_addr, 32'h0000_1000);
        tick();
        chk("redirH drop out_valid", 32'(out_valid), 32'd0);
        wait_out("redirH");
        chk("redirH out_pc", out_pc, 32'h0000_1000);
        chk("redirH out_instr", out_instr, 32'h0000_1000 ^ K);

        // Redirect with a full queue and a pop in the same cycle.
        do_reset();
        bus_ready = 1; resp_lat = 1; stall = 1;
        repeat (8) tick();
        chk("full out_valid", 32'(out_valid), 32'd1);
        chk("full ireq_valid", 32'(ireq_valid), 32'd0);
        stall = 0; redirect_valid = 1; redirect_pc = 32'h4000_0000;
        tick();
        chk("flush out_valid", 32'(out_valid), 32'd0);
        wait_out("flush");
        chk("flush out_pc", out_pc, 32'h4000_0000);

        // PC wraps from the top of the address space to zero.
        do_reset();
        bus_ready = 1; resp_lat = 1;
        redirect_valid = 1; redirect_pc = 32'hffff_fffe;
        tick();
        wait_req("wrap");
        chk("wrap ireq_addr", ireq_addr, 32'hffff_fffc);
        tick();
        chk("wrap next pc", ireq_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of a WAIT.
        do_reset();
        bus_ready = 1; resp_lat = 1; stall = 1;
        repeat (5) tick();
        chk("areset pre out_instr", out_instr, B ^ K);
        chk("areset pre ireq_addr", ireq_addr, B + 8);
        #2 reset = 1'b1;
        #1;
        chk("areset ireq_valid", 32'(ireq_valid), 32'd0);
        chk("areset ireq_addr", ireq_addr, B);
        chk("areset out_valid", 32'(out_valid), 32'd0);
        chk("areset out_pc", out_pc, 32'd0);
        chk("areset out_instr", out_instr, 32'd0);
        @(negedge clk);
        ireq_ready = 0; iresp_valid = 0; stall = 0; pend = 0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("areset first ireq_valid", 32'(ireq_valid), 32'd1);
        chk("areset first ireq_addr", ireq_addr, B);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
